// File: rtl/jpeg_rle.sv
// JPEG run/size/amplitude symbol generator for zigzag-ordered 8x8 coefficient blocks.
// Optional JPEG_RLE_DC_PRED_EN: differential DC coding with dc_clr; otherwise DC is coded raw.
module jpeg_rle #(
  parameter int COEF_W  = 11,
  parameter int BLK_LEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena_in,
  output logic              rdy_out,
  input  logic [COEF_W-1:0] in,
  input  logic              dc_clr,
  output logic              ena_out,
  input  logic              rdy_in,
  output logic [3:0]        out_run,
  output logic [3:0]        out_size,
  output logic [COEF_W-1:0] out_amp,
  output logic              out_dc,
  output logic              out_last
);
  localparam int IDX_W = $clog2(BLK_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [COEF_W:0]  ONE      = (COEF_W + 1)'(1);

  typedef enum logic {ACCEPT, DRAIN} state_t;
  state_t state, state_nxt;

  logic [IDX_W-1:0]  idx, zcnt, zrl_left, nz;
  logic [3:0]        hold_run, hold_size;
  logic [COEF_W-1:0] hold_amp;
  logic              hold_last;

  logic              acc, ofire, is_dc, is_last, is_zero;
  logic [COEF_W:0]   ac_v, dc_v, enc_v;
  logic [3:0]        enc_size;
  logic [COEF_W-1:0] enc_amp;

  logic              ld, hold_ld, ld_dc, ld_last;
  logic [3:0]        ld_run, ld_size;
  logic [COEF_W-1:0] ld_amp;

  function automatic logic [3:0] cat(input logic [COEF_W:0] v);
    logic [COEF_W:0] a;
    a = v[COEF_W] ? -v : v;
    cat = '0;
    for (int i = 0; i <= COEF_W; i++)
      if (a[i]) cat = 4'(i + 1);
  endfunction

  // Negative values are sent as (v-1) truncated to size bits (one's complement of |v|).
  function automatic logic [COEF_W-1:0] amp(input logic [COEF_W:0] v, input logic [3:0] sz);
    logic [COEF_W:0] m, mask;
    m    = v[COEF_W] ? v - ONE : v;
    mask = (ONE << sz) - ONE;
    amp  = COEF_W'(m & mask);
  endfunction

  assign acc     = ena_in && rdy_out;
  assign ofire   = ena_out && rdy_in;
  assign rdy_out = (state == ACCEPT) && (!ena_out || rdy_in);
  assign is_dc   = (idx == '0);
  assign is_last = (idx == LAST_IDX);
  assign is_zero = (in == '0);
  assign nz      = zcnt >> 4;
  assign ac_v    = {in[COEF_W-1], in};

`ifdef JPEG_RLE_DC_PRED_EN
  logic [COEF_W-1:0] pred, pred_eff;
  assign pred_eff = dc_clr ? '0 : pred;
  assign dc_v     = ac_v - {pred_eff[COEF_W-1], pred_eff};

  always_ff @(posedge clk or negedge rst)
    if (!rst)                pred <= '0;
    else if (acc && is_dc)   pred <= in;
`else
  logic unused_dc_clr;
  assign unused_dc_clr = dc_clr;
  assign dc_v          = ac_v;
`endif

  assign enc_v    = is_dc ? dc_v : ac_v;
  assign enc_size = cat(enc_v);
  assign enc_amp  = amp(enc_v, enc_size);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ACCEPT:  if (acc && !is_dc && !is_zero && nz != '0) state_nxt = DRAIN;
      DRAIN:   if (ofire && zrl_left == '0) state_nxt = ACCEPT;
      default: state_nxt = ACCEPT;
    endcase
  end

  // Picks the symbol loaded into the output register; a ZRL run first parks the AC symbol.
  always_comb begin
    ld      = 1'b0;
    hold_ld = 1'b0;
    ld_run  = '0;
    ld_size = '0;
    ld_amp  = '0;
    ld_dc   = 1'b0;
    ld_last = 1'b0;
    if (state == ACCEPT && acc) begin
      if (is_dc) begin
        ld      = 1'b1;
        ld_size = enc_size;
        ld_amp  = enc_amp;
        ld_dc   = 1'b1;
      end else if (!is_zero) begin
        ld = 1'b1;
        if (nz != '0) begin
          hold_ld = 1'b1;
          ld_run  = 4'hf;
        end else begin
          ld_run  = zcnt[3:0];
          ld_size = enc_size;
          ld_amp  = enc_amp;
          ld_last = is_last;
        end
      end else if (is_last) begin
        ld      = 1'b1;
        ld_last = 1'b1;
      end
    end else if (state == DRAIN && ofire) begin
      ld = 1'b1;
      if (zrl_left != '0) begin
        ld_run = 4'hf;
      end else begin
        ld_run  = hold_run;
        ld_size = hold_size;
        ld_amp  = hold_amp;
        ld_last = hold_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ACCEPT;
      idx       <= '0;
      zcnt      <= '0;
      zrl_left  <= '0;
      hold_run  <= '0;
      hold_size <= '0;
      hold_amp  <= '0;
      hold_last <= 1'b0;
      ena_out   <= 1'b0;
      out_run   <= '0;
      out_size  <= '0;
      out_amp   <= '0;
      out_dc    <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        idx  <= is_last ? '0 : idx + IDX_ONE;
        zcnt <= (is_zero && !is_dc && !is_last) ? zcnt + IDX_ONE : '0;
      end
      if (hold_ld) begin
        hold_run  <= zcnt[3:0];
        hold_size <= enc_size;
        hold_amp  <= enc_amp;
        hold_last <= is_last;
        zrl_left  <= nz - IDX_ONE;
      end else if (state == DRAIN && ofire && zrl_left != '0) begin
        zrl_left <= zrl_left - IDX_ONE;
      end
      if (ld) begin
        ena_out  <= 1'b1;
        out_run  <= ld_run;
        out_size <= ld_size;
        out_amp  <= ld_amp;
        out_dc   <= ld_dc;
        out_last <= ld_last;
      end else if (ofire) begin
        ena_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_jpeg_rle.sv
// Self-checking bench for jpeg_rle: random blocks against a symbol-list reference model.
module tb_jpeg_rle;
  localparam int COEF_W  = 11;
  localparam int BLK_LEN = 64;
  typedef int blk_t [BLK_LEN];

  logic clk = 1'b0;
  logic rst, ena_in, rdy_out, dc_clr, ena_out, out_dc, out_last;
  logic rdy_in = 1'b1;
  logic [COEF_W-1:0] in, out_amp;
  logic [3:0] out_run, out_size;

  always #5 clk = ~clk;

  jpeg_rle #(.COEF_W(COEF_W), .BLK_LEN(BLK_LEN)) dut (
    .clk(clk), .rst(rst), .ena_in(ena_in), .rdy_out(rdy_out), .in(in),
    .dc_clr(dc_clr), .ena_out(ena_out), .rdy_in(rdy_in), .out_run(out_run),
    .out_size(out_size), .out_amp(out_amp), .out_dc(out_dc), .out_last(out_last)
  );

  int n_cmp = 0, n_err = 0, n_sym = 0;
  int pred_m = 0;
  int rdy_mode = 0;
  bit mon_en = 0;
  logic [31:0] expq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bitlen(input int v);
    int a = (v < 0) ? -v : v;
    int s = 0;
    while (a != 0) begin a = a / 2; s++; end
    return s;
  endfunction

  function automatic int ampv(input int v, input int s);
    if (v >= 0) return v;
    return (v - 1) & ((1 << s) - 1);
  endfunction

  function automatic logic [31:0] sym(input int run, input int size, input int a,
                                      input bit dc, input bit last);
    return {11'd0, 4'(run), 4'(size), 11'(a), dc, last};
  endfunction

  function automatic void model_block(input blk_t c, input bit clr);
    int zc = 0;
    int d;
`ifdef JPEG_RLE_DC_PRED_EN
    d = c[0] - (clr ? 0 : pred_m);
`else
    d = c[0];
`endif
    pred_m = c[0];
    expq.push_back(sym(0, bitlen(d), ampv(d, bitlen(d)), 1'b1, 1'b0));
    for (int k = 1; k < BLK_LEN; k++) begin
      if (c[k] == 0) begin
        if (k == BLK_LEN - 1) expq.push_back(sym(0, 0, 0, 1'b0, 1'b1));
        else zc++;
      end else begin
        for (int z = zc; z >= 16; z -= 16) expq.push_back(sym(15, 0, 0, 1'b0, 1'b0));
        expq.push_back(sym(zc % 16, bitlen(c[k]), ampv(c[k], bitlen(c[k])), 1'b0,
                           k == BLK_LEN - 1));
        zc = 0;
      end
    end
  endfunction

  // rdy_in moves just after posedge so it is settled at the negedge decisions.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       rdy_in = ($urandom_range(0, 3) != 0);
      2:       rdy_in = 1'b0;
      default: rdy_in = 1'b1;
    endcase
  end

  logic [31:0] held_sym;
  bit held = 0;
  always @(negedge clk) begin
    logic [31:0] cur;
    cur = {11'd0, out_run, out_size, out_amp, out_dc, out_last};
    if (!mon_en) held = 0;
    else begin
      if (held) chk("hold_stable", {ena_out, cur[30:0]}, {1'b1, held_sym[30:0]});
      if (ena_out && out_run == 4'hf && out_size == 4'h0) chk("zrl_rdy_out", rdy_out, 0);
      if (ena_out && !rdy_in) chk("stall_rdy_out", rdy_out, 0);
      held = ena_out && !rdy_in;
      held_sym = cur;
      if (ena_out && rdy_in) begin
        n_sym++;
        if (expq.size() == 0) chk("extra_symbol", cur, 32'hffff_ffff);
        else chk("symbol", cur, expq.pop_front());
      end
    end
  end

  task automatic send_block(input blk_t c, input bit clr);
    model_block(c, clr);
    for (int k = 0; k < BLK_LEN; k++) begin
      int t = 0;
      ena_in = 1'b1;
      in     = COEF_W'(c[k]);
      dc_clr = clr;
      while (!rdy_out && t < 1000) begin @(negedge clk); t++; end
      if (t >= 1000) begin chk("rdy_out_timeout", t, 0); break; end
      @(posedge clk);
      @(negedge clk);
    end
    ena_in = 1'b0;
    dc_clr = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((expq.size() != 0 || ena_out) && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) chk("drain_timeout", expq.size(), 0);
  endtask

  function automatic blk_t zero_blk();
    blk_t b;
    foreach (b[i]) b[i] = 0;
    return b;
  endfunction

  function automatic blk_t rand_blk();
    blk_t b;
    int dens = $urandom_range(0, 8);
    b[0] = int'($urandom_range(0, 2000)) - 1000;
    for (int i = 1; i < BLK_LEN; i++)
      b[i] = (int'($urandom_range(0, 15)) < dens) ? int'($urandom_range(0, 2046)) - 1023 : 0;
    return b;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t b, b2;
    int s0;
    rst = 1'b0; ena_in = 1'b0; in = '0; dc_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ena_out", ena_out, 0);
    chk("rst_outs", {out_run, out_size, out_amp, out_dc, out_last}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", rdy_out, 1);
    mon_en = 1;

    // DC only, all AC zero: DC symbol then EOB
    b = zero_blk(); b[0] = 5;
    s0 = n_sym; send_block(b, 0); wait_drain();
    chk("blk1_count", n_sym - s0, 2);

    // DC predictor with and without dc_clr
    b = zero_blk(); b[0] = 3;
    send_block(b, 0); wait_drain();
    send_block(b, 1); wait_drain();

    // one ZRL before a -1 at idx 20
    b = zero_blk(); b[20] = -1;
    s0 = n_sym; send_block(b, 0); wait_drain();
    chk("zrl1_count", n_sym - s0, 4);

    // 62 zeros then +1 at the last index: 3 ZRLs, last AC symbol, no EOB
    b = zero_blk(); b[63] = 1;
    s0 = n_sym; send_block(b, 0); wait_drain();
    chk("zrl3_count", n_sym - s0, 5);

    // back-to-back blocks with a 5-cycle downstream stall mid-stream
    b = rand_blk(); b2 = rand_blk();
    fork
      begin send_block(b, 0); send_block(b2, 0); end
      begin
        repeat (40) @(posedge clk);
        rdy_mode = 2;
        repeat (5) @(posedge clk);
        rdy_mode = 0;
      end
    join
    wait_drain();

    // random blocks under random backpressure
    rdy_mode = 1;
    for (int n = 0; n < 24; n++) begin
      b = rand_blk();
      send_block(b, ($urandom_range(0, 5) == 0));
    end
    wait_drain();
    rdy_mode = 0;
    @(negedge clk);

    // async reset mid-block while a symbol is pending
    mon_en = 0;
    for (int k = 0; k < 30; k++) begin
      int t = 0;
      ena_in = 1'b1;
      in = (k == 0) ? COEF_W'(4) : COEF_W'(1);
      while (!rdy_out && t < 100) begin @(negedge clk); t++; end
      @(posedge clk);
      @(negedge clk);
    end
    ena_in = 1'b0;
    chk("pre_rst_ena_out", ena_out, 1);
    #2 rst = 1'b0;
    #1 chk("async_rst_ena_out", ena_out, 0);
    @(negedge clk);
    rst = 1'b1;
    expq.delete();
    pred_m = 0;
    @(negedge clk);
    chk("rdy_after_rst2", rdy_out, 1);
    mon_en = 1;
    b = zero_blk(); b[0] = 7;
    s0 = n_sym; send_block(b, 0); wait_drain();
    chk("post_rst_count", n_sym - s0, 2);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
